// File: rtl/burst_pkg.sv
// Shared constants and types for the 4-beat x 64-bit burst memory responder.
package burst_pkg;

    localparam int BEATS    = 4;
    localparam int BEAT_W   = 64;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RBURST,
        ST_WBURST,
        ST_DONE
    } state_t;

    typedef logic [1:0] beat_idx_t;

endpackage

// File: rtl/burst_line_store.sv
// Line store: DEPTH_LINES x 256-bit register array with one write port and a
// registered (1-cycle) read port. Contents are deliberately not reset.
module burst_line_store
    import burst_pkg::*;
#(
    parameter int DEPTH_LINES = 16,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [LINE_W-1:0] wr_line_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [LINE_W-1:0] rd_line_o
);

    logic [LINE_W-1:0] mem_q [DEPTH_LINES];
    logic [LINE_W-1:0] rd_line_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_line_i;
        end
        rd_line_q <= mem_q[rd_idx_i];
    end

    assign rd_line_o = rd_line_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: answers 4-beat read/write bursts from a line store
// after a programmable first-beat latency. Optional macro BURST_RESP_PROTOCOL_CHECK_EN
// enables a sticky protocol error flag on error_o.
module burst_mem_responder
    import burst_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o,
    output logic              error_o
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    // WAIT lasts LATENCY-1 cycles; the counter is loaded so that it expires on the last one.
    localparam logic [3:0] LAT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t            state_q, state_d;
    beat_idx_t         beat_q, beat_d;
    logic [3:0]        lat_q, lat_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              is_rd_q, is_rd_d;
    logic              ld_q, ld_d;
    logic [LINE_W-1:0] buf_q, buf_d;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [LINE_W-1:0] rd_line;
    logic [LINE_W-1:0] rd_src;
    logic              req_active;
    logic              commit;
    logic              unused_addr;

    assign req_idx     = address_i[OFFSET_W +: IDX_W];
    assign unused_addr = ^{address_i[OFFSET_W-1:0], address_i[31:OFFSET_W+IDX_W]};
    assign req_active  = is_rd_q ? read_i : write_i;
    assign rd_idx      = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign commit      = (state_q == ST_DONE) && !is_rd_q;

    burst_line_store #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_store (
        .clk       (clk),
        .we_i      (commit),
        .wr_idx_i  (idx_q),
        .wr_line_i (buf_q),
        .rd_idx_i  (rd_idx),
        .rd_line_o (rd_line)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        is_rd_d = is_rd_q;
        ld_d    = 1'b0;
        buf_d   = buf_q;

        // The store output is valid for exactly one cycle after a read is accepted.
        if (ld_q) begin
            buf_d = rd_line;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (read_i || write_i) begin
                    is_rd_d = read_i;
                    idx_d   = req_idx;
                    ld_d    = read_i;
                    lat_d   = LAT_INIT;
                    beat_d  = '0;
                    if (LATENCY == 1) begin
                        state_d = read_i ? ST_RBURST : ST_WBURST;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_active) begin
                    state_d = ST_IDLE;
                end else if (lat_q == 4'd0) begin
                    state_d = is_rd_q ? ST_RBURST : ST_WBURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_RBURST, ST_WBURST: begin
                if (!req_active) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    if (state_q == ST_WBURST) begin
                        buf_d[int'(beat_q)*BEAT_W +: BEAT_W] = burst_i;
                    end
                    if (beat_q == 2'd3) begin
                        state_d = ST_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            is_rd_q <= 1'b0;
            ld_q    <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            is_rd_q <= is_rd_d;
            ld_q    <= ld_d;
            buf_q   <= buf_d;
        end
    end

    assign rd_src  = ld_q ? rd_line : buf_q;
    assign resp_o  = (state_q == ST_RBURST) || (state_q == ST_WBURST);
    assign burst_o = (state_q == ST_RBURST) ? rd_src[int'(beat_q)*BEAT_W +: BEAT_W] : '0;

`ifdef BURST_RESP_PROTOCOL_CHECK_EN
    logic                  err_q, err_d;
    logic [31-OFFSET_W:0]  tag_q, tag_d;
    logic                  in_xfer;

    assign in_xfer = (state_q == ST_WAIT) || resp_o;
    assign tag_d   = (state_q == ST_IDLE) ? address_i[31:OFFSET_W] : tag_q;
    assign err_d   = err_q
                   || (read_i && write_i)
                   || (in_xfer && (address_i[31:OFFSET_W] != tag_q))
                   || (in_xfer && !req_active);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
            tag_q <= '0;
        end else begin
            err_q <= err_d;
            tag_q <= tag_d;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
